// File: rtl/fpu_pkg.sv
// Shared FP32 constants, field layout and the result classification used
// between the fmul rounding logic and the output packer.
package fpu_pkg;

  localparam int          EXP_BIAS  = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    RES_NORM,
    RES_ZERO,
    RES_UFL,
    RES_OVF
  } res_kind_e;

  typedef struct packed {
    logic        sign;
    res_kind_e   kind;
    logic [7:0]  exp;
    logic [22:0] mant;
  } rnd_t;

  function automatic fp32_t pack_result(input rnd_t r);
    fp32_t y;
    y = '0;
    case (r.kind)
      RES_NORM: y = {r.sign, r.exp, r.mant};
      RES_OVF:  y = FP32_PINF | {r.sign, 31'b0};
      default:  y = {r.sign, 31'b0};
    endcase
    return y;
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational normalize + round-to-nearest-even of the raw significand
// product, classifying the result as normal, zero, underflow or overflow.
module fmul_round
  import fpu_pkg::*;
(
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [25:0] in_frac,
  input  logic        in_zero,
  output rnd_t        rnd
);

  localparam logic signed [9:0] BIAS_S = EXP_BIAS[9:0];
  localparam logic signed [9:0] EXP_HI = EXP_MAX[9:0];

  logic [22:0]       mant;
  logic [22:0]       mant_r;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic              carry;
  logic signed [9:0] exp_s;
  logic signed [9:0] exp_r;

  always_comb begin
    if (in_frac[25]) begin
      mant   = in_frac[24:2];
      guard  = in_frac[1];
      sticky = in_frac[0];
    end else begin
      mant   = in_frac[23:1];
      guard  = in_frac[0];
      sticky = 1'b0;
    end
    // a lead at bit 25 means the product is already one binade higher
    exp_s = $signed({1'b0, in_exp}) - BIAS_S + $signed({9'b0, in_frac[25]});

    inc             = guard && (sticky || mant[0]);
    {carry, mant_r} = {1'b0, mant} + {23'b0, inc};
    exp_r           = exp_s + $signed({9'b0, carry});

    rnd.sign = in_sign;
    rnd.exp  = exp_r[7:0];
    rnd.mant = mant_r;
    if (in_zero)
      rnd.kind = RES_ZERO;
    else if (exp_r <= 10'sd0)
      rnd.kind = RES_UFL;
    else if (exp_r >= EXP_HI)
      rnd.kind = RES_OVF;
    else
      rnd.kind = RES_NORM;
  end

endmodule

// File: rtl/fmul_pack.sv
// Two-stage round/pack pipeline for the FP32 multiplier with valid/ready
// handshakes and flush. Define FMUL_PACK_EXC_EN to add the out_exc {ovf,ufl} port.
module fmul_pack
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
)
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [8:0]       in_exp,
  input  logic [25:0]      in_frac,
  input  logic             in_zero,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
`ifdef FMUL_PACK_EXC_EN
  ,
  output logic [1:0]       out_exc
`endif
);

  rnd_t             rnd_next;
  rnd_t             s1_rnd_reg;
  logic             s1_valid_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s2_valid_reg;
  fp32_t            s2_y_reg;
  logic [TAG_W-1:0] s2_tag_reg;
`ifdef FMUL_PACK_EXC_EN
  logic [1:0]       s2_exc_reg;
`endif
  logic             s2_adv;
  logic             s1_free;

  fmul_round u_round (
    .in_sign (in_sign),
    .in_exp  (in_exp),
    .in_frac (in_frac),
    .in_zero (in_zero),
    .rnd     (rnd_next)
  );

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_free  = !s1_valid_reg || s2_adv;
  // nothing may enter while the pipeline is being cleared
  assign in_ready = !rstn && !flush && s1_free;

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_valid_reg <= 1'b0;
      s1_rnd_reg   <= '0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_y_reg     <= '0;
      s2_tag_reg   <= '0;
`ifdef FMUL_PACK_EXC_EN
      s2_exc_reg   <= 2'b00;
`endif
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_y_reg   <= pack_result(s1_rnd_reg);
          s2_tag_reg <= s1_tag_reg;
`ifdef FMUL_PACK_EXC_EN
          s2_exc_reg <= {s1_rnd_reg.kind == RES_OVF, s1_rnd_reg.kind == RES_UFL};
`endif
        end
      end
      if (s1_free) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_rnd_reg <= rnd_next;
          s1_tag_reg <= in_tag;
        end
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_y     = s2_y_reg;
  assign out_tag   = s2_tag_reg;
`ifdef FMUL_PACK_EXC_EN
  assign out_exc   = s2_exc_reg;
`endif

endmodule

// File: doc/fmul_pack.md
FMUL_PACK -- requirements
Module: fmul_pack

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports named clk and rstn as elsewhere in the FPU (rstn=1 resets).
REQ-002 Parameter: TAG_W, default 5, width of the pass-through destination tag.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rstn  in  1  synchronous active-high reset.
REQ-005 flush  in  1  squashes all in-flight results.
REQ-006 in_valid/in_ready  in/out  1/1  upstream handshake from the multiplier core.
REQ-007 in_sign  in  1  product sign.
REQ-008 in_exp  in  9  raw exponent sum e1+e2 (0..510).
REQ-009 in_frac  in  26  significand product, leading one at bit 25 or bit 24.
REQ-010 in_zero  in  1  either operand zero or denormal.
REQ-011 in_tag  in  TAG_W  destination tag.
REQ-012 out_valid/out_ready  out/in  1/1  downstream handshake.
REQ-013 out_y  out  32  packed IEEE-754 single result.
REQ-014 out_tag  out  TAG_W  tag of out_y.

Function
REQ-015 Two registered stages: S1 holds normalized/rounded fields, S2 holds the packed result; latency 2 cycles, throughput 1/cycle.
REQ-016 Transfer occurs on valid&&ready; S2 advances when !out_valid||out_ready; S1 advances when S2 empty or advancing; in_ready = !S1.valid || S1 advancing.
REQ-017 in_frac[25]=1: mant=frac[24:2], guard=frac[1], sticky=frac[0], exp=in_exp-126.
REQ-018 in_frac[25]=0: mant=frac[23:1], guard=frac[0], sticky=0, exp=in_exp-127.
REQ-019 Round to nearest even: increment if guard && (sticky || mant[0]); mantissa carry-out sets mant=0 and exp+=1.
REQ-020 Exponent is computed signed at 10 bits; exp<=0 gives signed zero (flush, no denormals); exp>=255 gives signed infinity 0x7F800000|sign<<31.
REQ-021 in_zero=1 gives {in_sign,31'b0} regardless of the other fields.
REQ-022 Held outputs (out_valid=1, out_ready=0) SHALL remain stable until accepted.
REQ-023 flush clears both stage valids next edge; in_ready=0 during the flush cycle; flush wins over a simultaneous accept.
REQ-024 out_tag SHALL travel with its result unchanged.

Reset
REQ-025 On rstn=1: stage valids=0, out_valid=0, out_y=0, out_tag=0; in_ready=0 during reset, 1 the cycle after.
REQ-026 Reset mid-operation discards all in-flight results; no output is produced for them.

Configuration
REQ-027 Macro FMUL_PACK_EXC_EN defined: adds output out_exc[1:0]={ovf,ufl}, registered alongside out_y, reset 0, flags per REQ-020 (in_zero sets neither).
REQ-028 Macro undefined: port out_exc absent; the saturate/flush results are unchanged.

Structure
REQ-029 Package fpu_pkg SHALL hold EXP_BIAS=127, EXP_MAX=255, FP32_PINF=32'h7F800000 and the fp32 sign/exp/mant packed struct typedef.
REQ-030 Combinational normalize+round logic SHALL be a sub-module fmul_round, instantiated in front of S1; fmul_pack holds the pipeline and handshake.

Verification
REQ-031 in_exp=254, in_frac=26'h1000000, sign 0 -> out_y=32'h3F800000 two cycles later.
REQ-032 in_exp=254, in_frac=26'h2400000 (1.5*1.5) -> out_y=32'h40100000.
REQ-033 Rounding: in_frac=26'h1000003, in_exp=254 -> 32'h3F800002; in_frac=26'h1000001 -> 32'h3F800000 (tie to even); all-ones frac with bit 24 lead -> mantissa carry, exponent+1.
REQ-034 Boundaries: in_exp=400, sign 1 -> 32'hFF800000 (ovf=1 with EXC_EN); in_exp=100 -> 32'h00000000 (ufl=1); in_zero=1, sign 1 -> 32'h80000000.
REQ-035 Backpressure: out_ready=0 for 4 cycles with 4 back-to-back inputs -> exactly 2 accepted, in_ready=0 afterward, all results in order with matching tags once out_ready=1.
REQ-036 flush, or rstn pulsed, with 2 results in flight -> out_valid=0 next cycle, those results never appear, and the next input completes normally.
